// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO pointer/flag controller.
// Used by fifo_ptr and fifo_ctrl.
package fifo_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_RD  = 2'b01,
        OP_WR  = 2'b10,
        OP_RW  = 2'b11
    } fifo_op_t;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer register: advances by one on inc and wraps by natural
// overflow of its width. Asynchronous active-low reset to zero.
module fifo_ptr #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    logic [WIDTH-1:0] ptr_d;
    logic [WIDTH-1:0] ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a first-word-fall-through FIFO in front of
// a register file. Optional sticky error flags: define FIFO_CTRL_ERR_EN.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int addr_width = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic                  wr_en,
    output logic [addr_width-1:0] push_addr,
    output logic [addr_width-1:0] pop_addr,
    output logic                  full,
    output logic                  empty,
    output logic [addr_width:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH     = fifo_depth(addr_width);
    localparam logic [addr_width:0] DEPTH_CNT = DEPTH[addr_width:0];
    localparam logic [addr_width:0] ONE_CNT   = (addr_width + 1)'(1);

    logic            push_ok;
    logic            pop_ok;
    fifo_op_t        op;
    logic [addr_width:0] count_d;
    logic [addr_width:0] count_q;
    logic            full_d;
    logic            full_q;
    logic            empty_d;
    logic            empty_q;

    // Acceptance uses the registered flags, so a push and pop in the same
    // cycle never see each other's effect.
    always_comb begin
        push_ok = wr & ~full_q;
        pop_ok  = rd & ~empty_q;
        op      = fifo_op_t'({push_ok, pop_ok});
        count_d = count_q;
        full_d  = full_q;
        empty_d = empty_q;
        unique case (op)
            OP_WR: begin
                count_d = count_q + ONE_CNT;
                empty_d = 1'b0;
                full_d  = ((count_q + ONE_CNT) == DEPTH_CNT);
            end
            OP_RD: begin
                count_d = count_q - ONE_CNT;
                full_d  = 1'b0;
                empty_d = ((count_q - ONE_CNT) == '0);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    fifo_ptr #(
        .WIDTH (addr_width)
    ) u_push_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push_ok),
        .ptr   (push_addr)
    );

    fifo_ptr #(
        .WIDTH (addr_width)
    ) u_pop_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pop_ok),
        .ptr   (pop_addr)
    );

    assign wr_en = push_ok;
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

`ifdef FIFO_CTRL_ERR_EN
    logic overflow_d;
    logic overflow_q;
    logic underflow_d;
    logic underflow_q;

    // A new error in the same cycle as clr_err wins, so it is never lost.
    always_comb begin
        overflow_d  = (wr & full_q)  | (overflow_q  & ~clr_err);
        underflow_d = (rd & empty_q) | (underflow_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a local 4x8 storage array and a
// queue-based reference model; compile with FIFO_CTRL_ERR_EN to check errors.
module tb_fifo_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic          clr_err = 1'b0;
    logic [7:0]    w_data = 8'h00;
    logic          wr_en;
    logic [AW-1:0] push_addr;
    logic [AW-1:0] pop_addr;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    logic [7:0]    mem [DEPTH];
    logic [7:0]    r_data;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Reference model: a queue of stored bytes plus plain modular pointers
    logic [7:0] mq[$];
    int         m_push = 0;
    int         m_pop = 0;
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;

    fifo_ctrl #(
        .addr_width (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr        (wr),
        .rd        (rd),
        .clr_err   (clr_err),
        .wr_en     (wr_en),
        .push_addr (push_addr),
        .pop_addr  (pop_addr),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Stand-in for the register_file storage array
    always @(posedge clk) begin
        if (wr_en) mem[push_addr] <= w_data;
    end
    assign r_data = mem[pop_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_push = 0;
            m_pop  = 0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            bit was_full;
            bit was_empty;
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
`ifdef FIFO_CTRL_ERR_EN
            m_ovf = (wr && was_full)  ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
            m_udf = (rd && was_empty) ? 1'b1 : (clr_err ? 1'b0 : m_udf);
`endif
            if (rd && !was_empty) begin
                void'(mq.pop_front());
                m_pop = (m_pop + 1) % DEPTH;
            end
            if (wr && !was_full) begin
                mq.push_back(w_data);
                m_push = (m_push + 1) % DEPTH;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic r, input logic [7:0] d, input logic c);
        @(posedge clk);
        #1;
        wr      = w;
        rd      = r;
        w_data  = d;
        clr_err = c;
    endtask

    // Compare process: every falling edge, DUT against model
    always @(negedge clk) begin
        if (cmp_en) begin
            int sz;
            sz = mq.size();
            checkOutput("count",     32'(count),     32'(sz));
            checkOutput("full",      32'(full),      32'(sz == DEPTH));
            checkOutput("empty",     32'(empty),     32'(sz == 0));
            checkOutput("push_addr", 32'(push_addr), 32'(m_push));
            checkOutput("pop_addr",  32'(pop_addr),  32'(m_pop));
            checkOutput("wr_en",     32'(wr_en),     32'(wr && (sz != DEPTH)));
            checkOutput("overflow",  32'(overflow),  32'(m_ovf));
            checkOutput("underflow", 32'(underflow), 32'(m_udf));
            checkOutput("full_and_empty", 32'(full && empty), 32'(0));
            if (sz != 0) checkOutput("r_data", 32'(r_data), 32'(mq[0]));
        end
    end

    initial begin
        logic [7:0] exp_data [4];
        exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;
        #2;
        checkOutput("lit_reset_count", 32'(count), 32'd0);
        checkOutput("lit_reset_empty", 32'(empty), 32'd1);
        checkOutput("lit_reset_full",  32'(full),  32'd0);
        checkOutput("lit_reset_ptrs",  32'({push_addr, pop_addr}), 32'd0);

        // Fill to full, then one rejected push
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, exp_data[i], 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h55, 1'b0);
        #2;
        checkOutput("lit_full",       32'(full),  32'd1);
        checkOutput("lit_full_count", 32'(count), 32'd4);
        checkOutput("lit_full_wr_en", 32'(wr_en), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        #2;
        checkOutput("lit_full_push_addr", 32'(push_addr), 32'd0);
`ifdef FIFO_CTRL_ERR_EN
        checkOutput("lit_overflow", 32'(overflow), 32'd1);
`endif

        // Drain in order, then one rejected pop
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
            #1 checkOutput("lit_pop_data", 32'(r_data), 32'(exp_data[i]));
        end
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        #2 checkOutput("lit_drained_empty", 32'(empty), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        #2 checkOutput("lit_pop_addr_wrap", 32'(pop_addr), 32'd0);
`ifdef FIFO_CTRL_ERR_EN
        checkOutput("lit_underflow", 32'(underflow), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        #2 checkOutput("lit_underflow_clr", 32'(underflow), 32'd0);
`endif

        // Simultaneous push and pop while empty: push only
        applyStimulus(1'b1, 1'b1, 8'h77, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        #2;
        checkOutput("lit_rw_empty_count", 32'(count),  32'd1);
        checkOutput("lit_rw_empty_data",  32'(r_data), 32'h77);

        // Randomised traffic; the compare process checks every cycle
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom), 1'($urandom_range(0, 15) == 0));
        end

        // Bring occupancy to 3, then assert reset asynchronously mid-cycle
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        while (mq.size() != 3) begin
            if (mq.size() < 3) applyStimulus(1'b1, 1'b0, 8'($urandom), 1'b0);
            else applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        end
        #2 checkOutput("lit_pre_reset_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        #1;
        checkOutput("lit_async_count", 32'(count), 32'd0);
        checkOutput("lit_async_empty", 32'(empty), 32'd1);
        checkOutput("lit_async_ptrs",  32'({push_addr, pop_addr}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'hA5, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        #1 checkOutput("lit_after_reset_data", 32'(r_data), 32'hA5);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        #2 checkOutput("lit_after_reset_empty", 32'(empty), 32'd1);

        repeat (2) @(posedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
